// File: rtl/platform_gen_if.sv
// Signal bundle between the platform generator and the player-movement side.
// The player side drives start/is_dead; the generator drives the track outputs.
interface platform_gen_if;
  logic        start;
  logic        is_dead;
  logic [2:0]  lines;
  logic        seg_valid;
  logic [10:0] seg_count;
  logic [1:0]  state_o;

  modport master (
    output start, is_dead,
    input  lines, seg_valid, seg_count, state_o
  );

  modport slave (
    input  start, is_dead,
    output lines, seg_valid, seg_count, state_o
  );
endinterface

// File: rtl/platform_gen.sv
// Track platform generator: shows all lines during warm-up, then emits one
// survivable LFSR-derived 3-line pattern per segment until the player dies.
module platform_gen #(
  parameter int unsigned SEG_LEN     = 130,     // 2..65535
  parameter int unsigned WARMUP_SEGS = 1,       // must be at least 1
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  platform_gen_if.slave bus
);

  localparam logic [15:0] SEG_LAST  = 16'(SEG_LEN - 1);
  localparam logic [15:0] WARM_LAST = 16'(WARMUP_SEGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WARMUP = 2'b01,
    ST_RUN    = 2'b10,
    ST_DEAD   = 2'b11
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic [15:0] warm_cnt_q;
  logic [15:0] lfsr_q;
  logic [2:0]  lines_q;
  logic        seg_valid_q;
  logic [10:0] seg_count_q;

  logic        at_boundary_s;
  logic [15:0] lfsr_d;
  logic [2:0]  cand_s;
  logic [2:0]  lines_d;
  logic [10:0] seg_count_d;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ 16'hB400;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

  // Next pattern: never empty, and always shares a line with the current one
  always_comb begin
    at_boundary_s = (timer_q == SEG_LAST);
    lfsr_d        = lfsr_step(lfsr_q);
    cand_s        = (lfsr_d[2:0] == 3'b000) ? 3'b111 : lfsr_d[2:0];
    lines_d       = ((cand_s & lines_q) == 3'b000) ? (cand_s | lines_q) : cand_s;
    seg_count_d   = (seg_count_q == 11'h7FF) ? seg_count_q : (seg_count_q + 11'd1);
  end

  // Game FSM; is_dead outranks a coincident segment boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= 16'd0;
      warm_cnt_q  <= 16'd0;
      lfsr_q      <= LFSR_SEED;
      lines_q     <= 3'b111;
      seg_valid_q <= 1'b0;
      seg_count_q <= 11'd0;
    end else begin
      seg_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          timer_q <= 16'd0;
          lines_q <= 3'b111;
          if (bus.start) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= 16'd0;
            seg_count_q <= 11'd0;
          end
        end
        ST_WARMUP: begin
          if (bus.is_dead) begin
            state_q <= ST_DEAD;
            lines_q <= 3'b000;
          end else if (at_boundary_s) begin
            timer_q <= 16'd0;
            if (warm_cnt_q == WARM_LAST) begin
              state_q     <= ST_RUN;
              lfsr_q      <= lfsr_d;
              lines_q     <= lines_d;
              seg_valid_q <= 1'b1;
              seg_count_q <= seg_count_d;
            end else begin
              warm_cnt_q <= warm_cnt_q + 16'd1;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        ST_RUN: begin
          if (bus.is_dead) begin
            state_q <= ST_DEAD;
            lines_q <= 3'b000;
          end else if (at_boundary_s) begin
            timer_q     <= 16'd0;
            lfsr_q      <= lfsr_d;
            lines_q     <= lines_d;
            seg_valid_q <= 1'b1;
            seg_count_q <= seg_count_d;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        ST_DEAD: begin
          timer_q <= 16'd0;
          if (bus.start) begin
            state_q     <= ST_WARMUP;
            warm_cnt_q  <= 16'd0;
            seg_count_q <= 11'd0;
            lines_q     <= 3'b111;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= 16'd0;
          lines_q <= 3'b111;
        end
      endcase
    end
  end

  assign bus.lines     = lines_q;
  assign bus.seg_valid = seg_valid_q;
  assign bus.seg_count = seg_count_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_platform_gen.sv
// Randomized bench for platform_gen: a default instance and a short-segment
// instance are checked against a segment-level model of the track rules.
module tb_platform_gen;

  localparam int FL = 2;   // fast instance segment length
  localparam int FW = 2;   // fast instance warm-up segments
  localparam int DL = 130;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int err_hold, err_seg, err_cnt, err_surv, err_warm;

  logic [15:0] m_lfsr;
  logic [2:0]  m_lines;
  int          m_count;

  platform_gen_if dif ();
  platform_gen_if fif ();

  platform_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  platform_gen #(.SEG_LEN(FL), .WARMUP_SEGS(FW)) u_fast (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Pattern rule: empty candidate becomes all lines; disjoint candidate is merged
  function automatic logic [2:0] next_pattern(input logic [2:0] cur, input logic [15:0] l);
    logic [2:0] c;
    c = l[2:0];
    if (c == 3'b000) c = 3'b111;
    if ((c & cur) == 3'b000) c = c | cur;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Warm-up of the fast instance, ending on the edge that shows the first pattern
  task automatic fast_warmup();
    err_warm = 0;
    for (int i = 0; i < FL * FW - 1; i++) begin
      tick();
      if (fif.state_o !== 2'b01 || fif.lines !== 3'b111 || fif.seg_valid !== 1'b0 ||
          fif.seg_count !== 11'd0) err_warm++;
    end
    tick();
    m_lfsr  = lfsr_next(m_lfsr);
    m_lines = next_pattern(3'b111, m_lfsr);
    m_count = 1;
    check("fast_warm_hold", err_warm, 0);
    check("fast_first_state", fif.state_o, 2'b10);
    check("fast_first_valid", fif.seg_valid, 1'b1);
    check("fast_first_lines", fif.lines, m_lines);
    check("fast_first_count", fif.seg_count, 1);
  endtask

  // n RUN segments on the fast instance, optionally with start wiggling randomly
  task automatic run_segs(input int n, input bit wiggle);
    logic [2:0] prev;
    err_hold = 0; err_seg = 0; err_cnt = 0; err_surv = 0;
    for (int s = 0; s < n; s++) begin
      for (int c = 1; c < FL; c++) begin
        if (wiggle) fif.start = 1'($urandom_range(0, 1));
        tick();
        if (fif.seg_valid !== 1'b0 || fif.lines !== m_lines ||
            fif.seg_count !== 11'(m_count) || fif.state_o !== 2'b10) err_hold++;
      end
      if (wiggle) fif.start = 1'($urandom_range(0, 1));
      tick();
      prev    = m_lines;
      m_lfsr  = lfsr_next(m_lfsr);
      m_lines = next_pattern(prev, m_lfsr);
      m_count = (m_count >= 2047) ? 2047 : m_count + 1;
      if (fif.seg_valid !== 1'b1 || fif.lines !== m_lines) err_seg++;
      if (fif.seg_count !== 11'(m_count)) err_cnt++;
      if (fif.lines == 3'b000 || (fif.lines & prev) == 3'b000) err_surv++;
    end
    fif.start = 1'b0;
    check("run_hold", err_hold, 0);
    check("run_pattern", err_seg, 0);
    check("run_count", err_cnt, 0);
    check("run_survivable", err_surv, 0);
  endtask

  initial begin
    dif.start = 1'b0; dif.is_dead = 1'b0;
    fif.start = 1'b0; fif.is_dead = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_lines", dif.lines, 3'b111);
    check("rst_valid", dif.seg_valid, 1'b0);
    check("rst_count", dif.seg_count, 0);
    check("rst_state", dif.state_o, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // is_dead is ignored in IDLE
    dif.is_dead = 1'b1; fif.is_dead = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("idle_dead_state", dif.state_o, 2'b00);
    check("idle_dead_lines", fif.lines, 3'b111);
    dif.is_dead = 1'b0; fif.is_dead = 1'b0;

    // Default instance: start at cycle 5, SEG_LEN cycles of all lines, then RUN
    dif.start = 1'b1;
    tick();
    dif.start = 1'b0;
    check("dflt_warm_state", dif.state_o, 2'b01);
    err_warm = 0;
    for (int i = 0; i < DL - 1; i++) begin
      tick();
      if (dif.lines !== 3'b111 || dif.seg_valid !== 1'b0 || dif.state_o !== 2'b01) err_warm++;
    end
    check("dflt_warm_hold", err_warm, 0);
    tick();
    m_lfsr  = lfsr_next(16'hACE1);
    m_lines = next_pattern(3'b111, m_lfsr);
    check("dflt_run_state", dif.state_o, 2'b10);
    check("dflt_run_valid", dif.seg_valid, 1'b1);
    check("dflt_run_lines", dif.lines, m_lines);
    check("dflt_run_count", dif.seg_count, 1);
    tick();
    check("dflt_valid_pulse", dif.seg_valid, 1'b0);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_lines", dif.lines, 3'b111);
    check("async_rst_count", dif.seg_count, 0);
    check("async_rst_state", dif.state_o, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_idle", dif.state_o, 2'b00);

    // Fast instance: warm-up, short run with start noise
    m_lfsr = 16'hACE1;
    fif.start = 1'b1;
    tick();
    fif.start = 1'b0;
    check("fast_start_state", fif.state_o, 2'b01);
    fast_warmup();
    run_segs(5, 1'b1);
    check("short_run_count", fif.seg_count, 6);

    // is_dead on the boundary cycle beats the segment update
    for (int c = 1; c < FL; c++) tick();
    fif.is_dead = 1'b1;
    tick();
    fif.is_dead = 1'b0;
    check("dead_state", fif.state_o, 2'b11);
    check("dead_lines", fif.lines, 3'b000);
    check("dead_valid", fif.seg_valid, 1'b0);
    check("dead_count", fif.seg_count, 6);
    for (int i = 0; i < 3; i++) tick();
    check("dead_hold_lines", fif.lines, 3'b000);
    check("dead_hold_count", fif.seg_count, 6);

    // start together with is_dead in DEAD restarts; LFSR continues
    fif.start = 1'b1; fif.is_dead = 1'b1;
    tick();
    fif.start = 1'b0; fif.is_dead = 1'b0;
    check("restart_state", fif.state_o, 2'b01);
    check("restart_count", fif.seg_count, 0);
    check("restart_lines", fif.lines, 3'b111);
    fast_warmup();
    run_segs(2100, 1'b1);
    check("sat_count", fif.seg_count, 2047);

    #3 rst_n = 1'b0;
    #1;
    check("fast_rst_lines", fif.lines, 3'b111);
    check("fast_rst_count", fif.seg_count, 0);
    check("fast_rst_state", fif.state_o, 2'b00);
    @(posedge clk);
    #2 rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
